// File: rtl/dec8b10b_lanes_sync_if.sv
// Word bus between the deserializer/aligner and the multi-lane 8b/10b decoder.
// The master side drives the raw symbols; the slave side returns decoded bytes and status.
interface dec8b10b_lanes_sync_if #(parameter int SYMS = 2);
  logic                ena;
  logic [10*SYMS-1:0]  datain;
  logic                rdforce;
  logic                rdin;
  logic                valid;
  logic [8*SYMS-1:0]   dataout;
  logic [SYMS-1:0]     kout;
  logic [SYMS-1:0]     kerr;
  logic [SYMS-1:0]     rderr;
  logic                rdout;
  logic                sync_status;
  logic [2:0]          err_credit;

  modport master (output ena, datain, rdforce, rdin,
                  input  valid, dataout, kout, kerr, rderr, rdout, sync_status, err_credit);
  modport slave  (input  ena, datain, rdforce, rdin,
                  output valid, dataout, kout, kerr, rderr, rdout, sync_status, err_credit);
endinterface

// File: rtl/dec8b10b_lanes_sync.sv
// SYMS-lane 8b/10b decoder with running disparity chained lane to lane,
// plus a comma-driven word-sync FSM with error-credit hysteresis.
module dec8b10b_lanes_sync #(
  parameter int SYMS       = 2,
  parameter int ACQ_COMMAS = 3,
  parameter int LOSS_ERRS  = 4,
  parameter int GOOD_RUN   = 4
) (
  input logic                  clk,
  input logic                  reset,
  dec8b10b_lanes_sync_if.slave bus
);
  localparam logic [8:0] ACQ_N  = 9'(ACQ_COMMAS);
  localparam logic [8:0] GOOD_N = 9'(GOOD_RUN);
  localparam logic [3:0] LOSS_N = 4'(LOSS_ERRS);

  typedef enum logic [1:0] {LOSS_OF_SYNC = 2'd0, ACQUIRE = 2'd1, SYNCED = 2'd2} state_t;

  // {exists, EDCBA} for a 6b sub-block written abcdei with a as MSB
  function automatic logic [5:0] dec6(input logic [5:0] s);
    case (s)
      6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
      6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
      6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
      6'b110001:            dec6 = {1'b1, 5'd3};
      6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
      6'b101001:            dec6 = {1'b1, 5'd5};
      6'b011001:            dec6 = {1'b1, 5'd6};
      6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
      6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
      6'b100101:            dec6 = {1'b1, 5'd9};
      6'b010101:            dec6 = {1'b1, 5'd10};
      6'b110100:            dec6 = {1'b1, 5'd11};
      6'b001101:            dec6 = {1'b1, 5'd12};
      6'b101100:            dec6 = {1'b1, 5'd13};
      6'b011100:            dec6 = {1'b1, 5'd14};
      6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
      6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
      6'b100011:            dec6 = {1'b1, 5'd17};
      6'b010011:            dec6 = {1'b1, 5'd18};
      6'b110010:            dec6 = {1'b1, 5'd19};
      6'b001011:            dec6 = {1'b1, 5'd20};
      6'b101010:            dec6 = {1'b1, 5'd21};
      6'b011010:            dec6 = {1'b1, 5'd22};
      6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
      6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
      6'b100110:            dec6 = {1'b1, 5'd25};
      6'b010110:            dec6 = {1'b1, 5'd26};
      6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
      6'b001110, 6'b001111, 6'b110000: dec6 = {1'b1, 5'd28};
      6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
      6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
      6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
      default:              dec6 = 6'd0;
    endcase
  endfunction

  function automatic logic [2:0] dec4(input logic [3:0] f);
    case (f)
      4'b1011, 4'b0100: dec4 = 3'd0;
      4'b1001:          dec4 = 3'd1;
      4'b0101:          dec4 = 3'd2;
      4'b1100, 4'b0011: dec4 = 3'd3;
      4'b1101, 4'b0010: dec4 = 3'd4;
      4'b1010:          dec4 = 3'd5;
      4'b0110:          dec4 = 3'd6;
      default:          dec4 = 3'd7;
    endcase
  endfunction

  function automatic logic is_k28(input logic [5:0] s);
    is_k28 = (s == 6'b001111) || (s == 6'b110000);
  endfunction

  function automatic logic is_kx7(input logic [5:0] s, input logic [3:0] f);
    is_kx7 = ((f == 4'b0111) && (s inside {6'b000101, 6'b001001, 6'b010001, 6'b100001})) ||
             ((f == 4'b1000) && (s inside {6'b111010, 6'b110110, 6'b101110, 6'b011110}));
  endfunction

  // Whole-symbol legality when entering with running disparity r (1 = RD+)
  function automatic logic legal_at(input logic [5:0] s, input logic [3:0] f, input logic r);
    logic [5:0] d6;
    logic [2:0] n6;
    logic [2:0] n4;
    logic       mid;
    logic       ok;
    d6  = dec6(s);
    n6  = 3'($countones(s));
    n4  = 3'($countones(f));
    ok  = d6[5];
    if (n6 == 3'd4) ok = ok & ~r;
    else if (n6 == 3'd2) ok = ok & r;
    else if (s == 6'b111000) ok = ok & ~r;
    else if (s == 6'b000111) ok = ok & r;
    else ok = ok;
    mid = (n6 == 3'd4) ? 1'b1 : ((n6 == 3'd2) ? 1'b0 : r);
    case (n4)
      3'd3:    ok = ok & ~mid;
      3'd1:    ok = ok & mid;
      3'd2:    ok = ok & ((f == 4'b1100) ? ~mid : ((f == 4'b0011) ? mid : 1'b1));
      default: ok = 1'b0;
    endcase
    // P7 is replaced by A7 where it would create a run of five; K28 never uses P7
    case (f)
      4'b1110: ok = ok & ~(is_k28(s) || (s inside {6'b100011, 6'b010011, 6'b001011}));
      4'b0001: ok = ok & ~(is_k28(s) || (s inside {6'b110100, 6'b101100, 6'b011100}));
      4'b0111: ok = ok & ((s inside {6'b100011, 6'b010011, 6'b001011, 6'b110000}) || is_kx7(s, f));
      4'b1000: ok = ok & ((s inside {6'b110100, 6'b101100, 6'b011100, 6'b001111}) || is_kx7(s, f));
      default: ok = ok;
    endcase
    legal_at = ok;
  endfunction

  logic [8*SYMS-1:0] dat_s;
  logic [SYMS-1:0]   k_s, kerr_s, rderr_s;
  logic              rd_s, comma_s, werr_s;
  logic              rd_r;
  state_t            state_r, state_n;
  logic [7:0]        acq_r, acq_n, good_r, good_n;
  logic [2:0]        credit_r, credit_n;
  logic [8:0]        acq_inc_s, good_inc_s;
  logic [3:0]        cred_inc_s;

  // Per-lane decode, running disparity flows from lane 0 to lane SYMS-1
  always_comb begin : decode
    logic       rd_c, ln, lp;
    logic [9:0] w;
    logic [5:0] s, x6;
    logic [3:0] f;
    logic [2:0] y;
    logic [3:0] n10;
    dat_s   = '0;
    k_s     = '0;
    kerr_s  = '0;
    rderr_s = '0;
    comma_s = 1'b0;
    werr_s  = 1'b0;
    rd_c    = bus.rdforce ? bus.rdin : rd_r;
    for (int k = 0; k < SYMS; k++) begin
      w   = bus.datain[10*k +: 10];
      s   = {w[0], w[1], w[2], w[3], w[4], w[5]};
      f   = {w[6], w[7], w[8], w[9]};
      x6  = dec6(s);
      y   = (s == 6'b110000) ? dec4(~f) : dec4(f);
      ln  = legal_at(s, f, 1'b0);
      lp  = legal_at(s, f, 1'b1);
      n10 = 4'($countones(w));
      if (!x6[5] || !(ln || lp)) begin
        kerr_s[k] = 1'b1;
      end else begin
        dat_s[8*k +: 8] = {y, x6[4:0]};
        k_s[k]          = is_k28(s) || is_kx7(s, f);
        rderr_s[k]      = rd_c ? ~lp : ~ln;
        if (is_k28(s) && (y inside {3'd1, 3'd5, 3'd7}) && !rderr_s[k]) comma_s = 1'b1;
        else comma_s = comma_s;
        if (n10 == 4'd6) rd_c = 1'b1;
        else if (n10 == 4'd4) rd_c = 1'b0;
        else rd_c = rd_c;
      end
      werr_s = werr_s | kerr_s[k] | rderr_s[k];
    end
    rd_s = rd_c;
  end

  // Sync FSM next state and counters; applied only on qualified words
  always_comb begin
    state_n    = state_r;
    acq_n      = acq_r;
    good_n     = good_r;
    credit_n   = credit_r;
    acq_inc_s  = {1'b0, acq_r} + 9'd1;
    good_inc_s = {1'b0, good_r} + 9'd1;
    cred_inc_s = {1'b0, credit_r} + 4'd1;
    case (state_r)
      LOSS_OF_SYNC: begin
        if (comma_s && !werr_s) begin
          acq_n = 8'd1;
          if (ACQ_N <= 9'd1) begin
            state_n  = SYNCED;
            credit_n = 3'd0;
            good_n   = 8'd0;
          end else begin
            state_n = ACQUIRE;
          end
        end else begin
          acq_n = 8'd0;
        end
      end
      ACQUIRE: begin
        if (werr_s) begin
          state_n = LOSS_OF_SYNC;
          acq_n   = 8'd0;
        end else if (comma_s) begin
          acq_n = acq_inc_s[8] ? acq_r : acq_inc_s[7:0];
          if (acq_inc_s >= ACQ_N) begin
            state_n  = SYNCED;
            credit_n = 3'd0;
            good_n   = 8'd0;
          end else begin
            state_n = ACQUIRE;
          end
        end else begin
          acq_n = acq_r;
        end
      end
      SYNCED: begin
        if (werr_s) begin
          good_n = 8'd0;
          if (cred_inc_s >= LOSS_N) begin
            state_n  = LOSS_OF_SYNC;
            credit_n = 3'd0;
            acq_n    = 8'd0;
          end else begin
            credit_n = cred_inc_s[2:0];
          end
        end else if (good_inc_s >= GOOD_N) begin
          // a full good run refunds one credit, otherwise the run counter parks
          if (credit_r != 3'd0) begin
            credit_n = credit_r - 3'd1;
            good_n   = 8'd0;
          end else begin
            good_n = GOOD_N[7:0];
          end
        end else begin
          good_n = good_inc_s[7:0];
        end
      end
      default: state_n = LOSS_OF_SYNC;
    endcase
  end

  // Output, running-disparity and FSM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid       <= 1'b0;
      bus.dataout     <= '0;
      bus.kout        <= '0;
      bus.kerr        <= '0;
      bus.rderr       <= '0;
      bus.sync_status <= 1'b0;
      rd_r            <= 1'b0;
      state_r         <= LOSS_OF_SYNC;
      acq_r           <= 8'd0;
      good_r          <= 8'd0;
      credit_r        <= 3'd0;
    end else begin
      bus.valid <= bus.ena;
      if (bus.ena) begin
        bus.dataout     <= dat_s;
        bus.kout        <= k_s;
        bus.kerr        <= kerr_s;
        bus.rderr       <= rderr_s;
        bus.sync_status <= (state_n == SYNCED);
        rd_r            <= rd_s;
        state_r         <= state_n;
        acq_r           <= acq_n;
        good_r          <= good_n;
        credit_r        <= credit_n;
      end
    end
  end

  assign bus.rdout      = rd_r;
  assign bus.err_credit = credit_r;
endmodule

// File: tb/tb_dec8b10b_lanes_sync.sv
// Directed bench for dec8b10b_lanes_sync: one 1-lane and one 2-lane instance
// driven with hand-encoded symbols and checked against hand-decoded values.
module tb_dec8b10b_lanes_sync;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dec8b10b_lanes_sync_if #(.SYMS(1)) if1 ();
  dec8b10b_lanes_sync_if #(.SYMS(2)) if2 ();

  dec8b10b_lanes_sync #(.SYMS(1), .ACQ_COMMAS(3), .LOSS_ERRS(4), .GOOD_RUN(4))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  dec8b10b_lanes_sync #(.SYMS(2), .ACQ_COMMAS(3), .LOSS_ERRS(4), .GOOD_RUN(4))
    dut2 (.clk(clk), .reset(reset), .bus(if2));

  task automatic step1(input logic en, input logic [9:0] w, input logic f, input logic r);
    @(negedge clk);
    if1.ena = en; if1.datain = w; if1.rdforce = f; if1.rdin = r;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic en, input logic [19:0] w);
    @(negedge clk);
    if2.ena = en; if2.datain = w; if2.rdforce = 1'b0; if2.rdin = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    if1.ena = 1'b1; if1.datain = 10'h17C; if1.rdforce = 1'b0; if1.rdin = 1'b0;
    if2.ena = 1'b1; if2.datain = {10'h17C, 10'h17C}; if2.rdforce = 1'b0; if2.rdin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0; if1.ena = 1'b0; if2.ena = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (if1.valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", if1.valid); end
    checks++; if (if1.dataout !== 8'h00) begin failures++; $display("FAIL rst_dataout got=%h want=00", if1.dataout); end
    checks++; if (if1.kout !== 1'b0) begin failures++; $display("FAIL rst_kout got=%b want=0", if1.kout); end
    checks++; if (if1.kerr !== 1'b0) begin failures++; $display("FAIL rst_kerr got=%b want=0", if1.kerr); end
    checks++; if (if1.rderr !== 1'b0) begin failures++; $display("FAIL rst_rderr got=%b want=0", if1.rderr); end
    checks++; if (if1.rdout !== 1'b0) begin failures++; $display("FAIL rst_rdout got=%b want=0", if1.rdout); end
    checks++; if (if1.sync_status !== 1'b0) begin failures++; $display("FAIL rst_sync got=%b want=0", if1.sync_status); end
    checks++; if (if1.err_credit !== 3'd0) begin failures++; $display("FAIL rst_credit got=%0d want=0", if1.err_credit); end
    checks++; if (if2.dataout !== 16'h0000) begin failures++; $display("FAIL rst2_dataout got=%h want=0000", if2.dataout); end
    checks++; if (if2.rdout !== 1'b0) begin failures++; $display("FAIL rst2_rdout got=%b want=0", if2.rdout); end
  endtask

  task automatic test_single_k();
    step1(1'b1, 10'h17C, 1'b0, 1'b0);
    checks++; if (if1.valid !== 1'b1) begin failures++; $display("FAIL k285_valid got=%b want=1", if1.valid); end
    checks++; if (if1.dataout !== 8'hBC) begin failures++; $display("FAIL k285_dataout got=%h want=bc", if1.dataout); end
    checks++; if (if1.kout !== 1'b1) begin failures++; $display("FAIL k285_kout got=%b want=1", if1.kout); end
    checks++; if (if1.kerr !== 1'b0) begin failures++; $display("FAIL k285_kerr got=%b want=0", if1.kerr); end
    checks++; if (if1.rderr !== 1'b0) begin failures++; $display("FAIL k285_rderr got=%b want=0", if1.rderr); end
    checks++; if (if1.rdout !== 1'b1) begin failures++; $display("FAIL k285_rdout got=%b want=1", if1.rdout); end
  endtask

  task automatic test_rd_errors();
    do_reset();
    step1(1'b1, 10'h283, 1'b0, 1'b0);
    checks++; if (if1.rderr !== 1'b1) begin failures++; $display("FAIL rderr_flag got=%b want=1", if1.rderr); end
    checks++; if (if1.kerr !== 1'b0) begin failures++; $display("FAIL rderr_kerr got=%b want=0", if1.kerr); end
    checks++; if (if1.dataout !== 8'hBC) begin failures++; $display("FAIL rderr_dataout got=%h want=bc", if1.dataout); end
    checks++; if (if1.rdout !== 1'b0) begin failures++; $display("FAIL rderr_rdout got=%b want=0", if1.rdout); end
    // invalid 6b 111100 with six ones overall: RD must not move
    step1(1'b1, 10'h0CF, 1'b0, 1'b0);
    checks++; if (if1.kerr !== 1'b1) begin failures++; $display("FAIL kerr_flag got=%b want=1", if1.kerr); end
    checks++; if (if1.rderr !== 1'b0) begin failures++; $display("FAIL kerr_rderr got=%b want=0", if1.rderr); end
    checks++; if (if1.dataout !== 8'h00) begin failures++; $display("FAIL kerr_dataout got=%h want=00", if1.dataout); end
    checks++; if (if1.kout !== 1'b0) begin failures++; $display("FAIL kerr_kout got=%b want=0", if1.kout); end
    checks++; if (if1.rdout !== 1'b0) begin failures++; $display("FAIL kerr_rdout got=%b want=0", if1.rdout); end
  endtask

  task automatic test_two_lanes();
    do_reset();
    step2(1'b1, {10'h283, 10'h17C});
    checks++; if (if2.dataout !== 16'hBCBC) begin failures++; $display("FAIL l2_k_dataout got=%h want=bcbc", if2.dataout); end
    checks++; if (if2.kout !== 2'b11) begin failures++; $display("FAIL l2_k_kout got=%b want=11", if2.kout); end
    checks++; if (if2.rderr !== 2'b00) begin failures++; $display("FAIL l2_k_rderr got=%b want=00", if2.rderr); end
    checks++; if (if2.rdout !== 1'b0) begin failures++; $display("FAIL l2_k_rdout got=%b want=0", if2.rdout); end
    step2(1'b1, {10'h155, 10'h155});
    checks++; if (if2.dataout !== 16'hB5B5) begin failures++; $display("FAIL l2_d_dataout got=%h want=b5b5", if2.dataout); end
    checks++; if (if2.kout !== 2'b00) begin failures++; $display("FAIL l2_d_kout got=%b want=00", if2.kout); end
    checks++; if (if2.rdout !== 1'b0) begin failures++; $display("FAIL l2_d_rdout got=%b want=0", if2.rdout); end
    // lane 1 sees lane 0's exit RD+ and so rejects the RD- form of K28.5
    step2(1'b1, {10'h17C, 10'h17C});
    checks++; if (if2.rderr !== 2'b10) begin failures++; $display("FAIL l2_chain_rderr got=%b want=10", if2.rderr); end
    checks++; if (if2.dataout !== 16'hBCBC) begin failures++; $display("FAIL l2_chain_dataout got=%h want=bcbc", if2.dataout); end
    checks++; if (if2.rdout !== 1'b1) begin failures++; $display("FAIL l2_chain_rdout got=%b want=1", if2.rdout); end
    step2(1'b1, {10'h000, 10'h155});
    checks++; if (if2.kerr !== 2'b10) begin failures++; $display("FAIL l2_kerr_kerr got=%b want=10", if2.kerr); end
    checks++; if (if2.dataout !== 16'h00B5) begin failures++; $display("FAIL l2_kerr_dataout got=%h want=00b5", if2.dataout); end
    checks++; if (if2.rdout !== 1'b1) begin failures++; $display("FAIL l2_kerr_rdout got=%b want=1", if2.rdout); end
  endtask

  task automatic test_sync_acquire();
    logic [9:0] seq [5];
    logic       exp [5];
    do_reset();
    step1(1'b1, 10'h17C, 1'b0, 1'b0);
    checks++; if (if1.sync_status !== 1'b0) begin failures++; $display("FAIL acq_w1 got=%b want=0", if1.sync_status); end
    step1(1'b1, 10'h283, 1'b0, 1'b0);
    checks++; if (if1.sync_status !== 1'b0) begin failures++; $display("FAIL acq_w2 got=%b want=0", if1.sync_status); end
    step1(1'b1, 10'h17C, 1'b0, 1'b0);
    checks++; if (if1.sync_status !== 1'b1) begin failures++; $display("FAIL acq_w3 got=%b want=1", if1.sync_status); end
    checks++; if (if1.err_credit !== 3'd0) begin failures++; $display("FAIL acq_credit got=%0d want=0", if1.err_credit); end
    // an error during ACQUIRE restarts the comma count from scratch
    do_reset();
    seq = '{10'h17C, 10'h000, 10'h283, 10'h17C, 10'h283};
    exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step1(1'b1, seq[i], 1'b0, 1'b0);
      checks++;
      if (if1.sync_status !== exp[i]) begin
        failures++; $display("FAIL acq_restart_w%0d got=%b want=%b", i, if1.sync_status, exp[i]);
      end
    end
  endtask

  task automatic test_hysteresis();
    logic [9:0] seq [9];
    logic [2:0] cred [9];
    logic       syn [9];
    seq  = '{10'h000, 10'h000, 10'h000, 10'h155, 10'h155, 10'h155, 10'h155, 10'h000, 10'h000};
    cred = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd3, 3'd0};
    syn  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step1(1'b1, seq[i], 1'b0, 1'b0);
      checks++;
      if (if1.err_credit !== cred[i]) begin
        failures++; $display("FAIL hyst_credit_w%0d got=%0d want=%0d", i, if1.err_credit, cred[i]);
      end
      checks++;
      if (if1.sync_status !== syn[i]) begin
        failures++; $display("FAIL hyst_sync_w%0d got=%b want=%b", i, if1.sync_status, syn[i]);
      end
    end
  endtask

  task automatic test_hold();
    step1(1'b1, 10'h17C, 1'b0, 1'b0);
    checks++; if (if1.dataout !== 8'hBC) begin failures++; $display("FAIL hold_pre_dataout got=%h want=bc", if1.dataout); end
    checks++; if (if1.rdout !== 1'b1) begin failures++; $display("FAIL hold_pre_rdout got=%b want=1", if1.rdout); end
    for (int i = 0; i < 5; i++) begin
      step1(1'b0, 10'h0CF, 1'b0, 1'b0);
      checks++; if (if1.valid !== 1'b0) begin failures++; $display("FAIL hold_valid_c%0d got=%b want=0", i, if1.valid); end
      checks++; if (if1.dataout !== 8'hBC) begin failures++; $display("FAIL hold_dataout_c%0d got=%h want=bc", i, if1.dataout); end
      checks++; if (if1.kerr !== 1'b0) begin failures++; $display("FAIL hold_kerr_c%0d got=%b want=0", i, if1.kerr); end
      checks++; if (if1.rdout !== 1'b1) begin failures++; $display("FAIL hold_rdout_c%0d got=%b want=1", i, if1.rdout); end
    end
    // acquisition resumes at count 2 only if RD and the FSM were frozen
    step1(1'b1, 10'h283, 1'b0, 1'b0);
    checks++; if (if1.rderr !== 1'b0) begin failures++; $display("FAIL hold_post_rderr got=%b want=0", if1.rderr); end
    checks++; if (if1.sync_status !== 1'b0) begin failures++; $display("FAIL hold_post_sync2 got=%b want=0", if1.sync_status); end
    step1(1'b1, 10'h17C, 1'b0, 1'b0);
    checks++; if (if1.sync_status !== 1'b1) begin failures++; $display("FAIL hold_post_sync3 got=%b want=1", if1.sync_status); end
  endtask

  task automatic test_rdforce();
    step1(1'b1, 10'h283, 1'b0, 1'b0);
    checks++; if (if1.rdout !== 1'b0) begin failures++; $display("FAIL force_pre_rdout got=%b want=0", if1.rdout); end
    step1(1'b1, 10'h283, 1'b1, 1'b1);
    checks++; if (if1.rderr !== 1'b0) begin failures++; $display("FAIL force_rderr got=%b want=0", if1.rderr); end
    checks++; if (if1.rdout !== 1'b0) begin failures++; $display("FAIL force_rdout got=%b want=0", if1.rdout); end
    checks++; if (if1.dataout !== 8'hBC) begin failures++; $display("FAIL force_dataout got=%h want=bc", if1.dataout); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    reset = 1'b1; if1.ena = 1'b1; if1.datain = 10'h17C; if1.rdforce = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (if1.valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", if1.valid); end
    checks++; if (if1.dataout !== 8'h00) begin failures++; $display("FAIL mid_rst_dataout got=%h want=00", if1.dataout); end
    checks++; if (if1.kout !== 1'b0) begin failures++; $display("FAIL mid_rst_kout got=%b want=0", if1.kout); end
    checks++; if (if1.rdout !== 1'b0) begin failures++; $display("FAIL mid_rst_rdout got=%b want=0", if1.rdout); end
    checks++; if (if1.sync_status !== 1'b0) begin failures++; $display("FAIL mid_rst_sync got=%b want=0", if1.sync_status); end
    checks++; if (if1.err_credit !== 3'd0) begin failures++; $display("FAIL mid_rst_credit got=%0d want=0", if1.err_credit); end
    @(negedge clk);
    reset = 1'b0; if1.ena = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    if1.ena = 1'b0; if1.datain = 10'h000; if1.rdforce = 1'b0; if1.rdin = 1'b0;
    if2.ena = 1'b0; if2.datain = 20'h00000; if2.rdforce = 1'b0; if2.rdin = 1'b0;
    test_reset();
    test_single_k();
    test_rd_errors();
    test_two_lanes();
    test_sync_acquire();
    test_hysteresis();
    test_hold();
    test_rdforce();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dec8b10b_lanes_sync.md
Name: dec8b10b_lanes_sync

Overview:
- Parametrised multi-lane 8b/10b decoder with running-disparity chaining across lanes.
- Adds a comma-based word-sync state machine with error hysteresis.
- Sits between the deserializer/aligner and the link layer; next generation of the single-lane Decodificador.
- Decodes SYMS symbols per clock, registers the result, and reports per-lane code/disparity errors plus a link-level sync status.

Parameters:
- SYMS, 2, number of 10-bit symbols decoded per clock (1..4); lane 0 is earliest in time.
- ACQ_COMMAS, 3, consecutive error-free words containing a comma needed to reach SYNCED.
- LOSS_ERRS, 4, error credit count that forces LOSS_OF_SYNC.
- GOOD_RUN, 4, consecutive error-free words that refund one error credit.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  input word qualifier.
- datain  in  10*SYMS  lane k at [10k+9:10k]; within a lane bit0=a … bit5=i, bit6=f … bit9=j.
- rdforce  in  1  when 1, lane 0 starting disparity is taken from rdin, not the internal RD.
- rdin  in  1  forced starting disparity (0=RD-, 1=RD+).
- valid  out  1  registered ena.
- dataout  out  8*SYMS  lane k at [8k+7:8k], HGF EDCBA order (H=bit7).
- kout  out  SYMS  lane is a valid K code.
- kerr  out  SYMS  lane is not a legal 10b code in either disparity.
- rderr  out  SYMS  legal code, but illegal for the running disparity at that lane.
- rdout  out  1  running disparity after the last lane.
- sync_status  out  1  1 while the FSM is in SYNCED.
- err_credit  out  3  current error credit (diagnostic).

Behaviour:
- Reset (synchronous, reset=1 at posedge clk):
  - valid, dataout, kout, kerr, rderr, sync_status and err_credit all go to 0.
  - rdout and internal RD go to 0 (RD-).
  - FSM goes to LOSS_OF_SYNC and all counters clear.
  - Reset asserted mid-stream discards the word sampled that cycle.
- Latency: 1 cycle. Outputs update on the posedge after a cycle with ena=1. With ena=0 all outputs hold, RD holds, valid=0, and the FSM holds.
- Decode per lane:
  - Split into 5b/6b and 3b/4b tables; D.x.A7 and K28.x handled per standard.
  - Illegal 6b or 4b sub-block, or an illegal combination → kerr=1, dataout=0x00, kout=0.
  - Legal code with disparity inconsistent with the lane's entering RD → rderr=1; data still decoded.
- Disparity chaining:
  - Lane 0 enters with (rdforce ? rdin : RD). Lane k+1 enters with lane k's exit RD.
  - Exit RD = RD+ if the symbol disparity is +2, RD- if -2, unchanged if 0. This rule also applies on rderr.
  - kerr lanes leave RD unchanged.
  - RD register and rdout take the last lane's exit RD.
- Word error: any lane with kerr|rderr. Comma word: any lane decodes K28.1, K28.5 or K28.7 without error.
- FSM (evaluated only when ena=1):
  - LOSS_OF_SYNC: comma word without error → ACQUIRE, acq_cnt=1.
  - ACQUIRE: word error → LOSS_OF_SYNC. Error-free comma word → acq_cnt+1; error-free non-comma word → hold. When acq_cnt reaches ACQ_COMMAS → SYNCED, err_credit=0.
  - SYNCED:
    - Word error → err_credit+1, good_cnt=0.
    - Error-free word → good_cnt+1. When good_cnt reaches GOOD_RUN and err_credit>0 → err_credit-1, good_cnt=0.
    - err_credit reaching LOSS_ERRS → LOSS_OF_SYNC, err_credit=0.
    - Error and refund in the same word cannot occur; the error takes priority.
- sync_status is registered, aligned with the word that caused the transition (same cycle as its dataout).
- Counters saturate; err_credit never exceeds LOSS_ERRS.

Test Plan:
- SYMS=1, reset, then datain=0x17C (K28.5 RD-) → next cycle dataout=0xBC, kout=1, kerr=0, rderr=0, rdout=1.
- SYMS=2, RD-, datain={0x283,0x17C} → dataout=0xBCBC, kout=2'b11, rderr=0, rdout=0. Then {0x155,0x155} (D21.5 x2) → dataout=0xB5B5, kout=0, rdout=0.
- SYMS=1, RD-, datain=0x283 → rderr=1, dataout=0xBC, rdout=0. Then datain=0x000 → kerr=1, dataout=0x00, rdout unchanged.
- Sync acquisition: 3 alternating K28.5 words (0x17C, 0x283, 0x17C) → sync_status=1 aligned with the third word. Insert a kerr word during ACQUIRE → sync_status stays 0 and the FSM returns to LOSS_OF_SYNC.
- Loss hysteresis, in SYNCED: 3 error words → err_credit=3, sync_status=1. 4 good words → err_credit=2. 2 more error words → err_credit reaches 4 → sync_status=0.
- ena=0 for 5 cycles mid-stream → outputs, RD and FSM hold, valid=0. Then rdforce=1, rdin=1 with datain=0x283 → rderr=0, rdout=0. Reset asserted mid-stream → all outputs 0 next cycle.
